// File: rtl/multi_idle_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multi_idle_scheduler
//  Brief    : Watches NUM_CH channels for idle periods. Each channel arms once
//             it has been idle for longer than its threshold and is out of its
//             post-test cooldown. A round-robin FSM hands one armed channel at
//             a time to a BIST engine, and aborts the test if the system
//             reclaims the channel.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_idle_scheduler #(
   parameter int NUM_CH      = 4,
   parameter int TIMER_WIDTH = 16,
   parameter int CD_WIDTH    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             sys_valid,
   input  logic [NUM_CH-1:0]             ch_enable,
   input  logic [NUM_CH*TIMER_WIDTH-1:0] threshold,
   input  logic [CD_WIDTH-1:0]           cooldown,
   output logic [NUM_CH-1:0]             ch_armed,
   output logic                          bist_req,
   output logic [$clog2(NUM_CH)-1:0]     bist_ch,
   input  logic                          bist_ack,
   input  logic                          bist_done,
   output logic                          bist_abort,
   output logic                          busy
);

   localparam int CH_W = $clog2(NUM_CH);
   // One extra bit so the round-robin index can exceed NUM_CH-1 before wrapping
   localparam int IW   = CH_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_TEST  = 2'd2;
   localparam logic [1:0] S_ABORT = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              bist_req_q, bist_req_d;
   logic              bist_abort_q, bist_abort_d;
   logic [CH_W-1:0]   bist_ch_q, bist_ch_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;     // first channel of the next search
   logic [NUM_CH-1:0] ch_armed_q;
   logic [NUM_CH-1:0] cd_load;                // test on channel completed normally
   logic [CH_W-1:0]   rr_winner;
   logic              rr_found;
   logic [IW-1:0]     rr_idx;
   logic              sel_valid;
   logic [CH_W-1:0]   next_ptr;

   // System activity on the channel currently handed to the engine
   assign sel_valid = sys_valid[bist_ch_q];
   // Search after a finished or aborted test starts just past that channel
   assign next_ptr  = (bist_ch_q == CH_W'(NUM_CH - 1)) ? '0 : bist_ch_q + CH_W'(1);

   // ------------------------------------------------------------------------
   // Per-channel idle timer, cooldown and arm flag
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;
      logic [TIMER_WIDTH-1:0] thr;
      logic [CD_WIDTH-1:0]    cd_q, cd_d;
      logic                   armed_q, armed_d;

      assign thr = threshold[i*TIMER_WIDTH +: TIMER_WIDTH];

      // Next idle count / cooldown / arm; decisions use pre-edge values
      always_comb begin
         cnt_d   = cnt_q;
         armed_d = armed_q;
         cd_d    = (cd_q != '0) ? cd_q - CD_WIDTH'(1) : cd_q;
         if (cd_load[i]) begin
            // Completed test: restart the idle window and hold off re-arming
            cd_d    = cooldown;
            cnt_d   = '0;
            armed_d = 1'b0;
         end else if (sys_valid[i] || !ch_enable[i]) begin
            cnt_d   = '0;
            armed_d = 1'b0;
         end else begin
            if (cnt_q < thr) begin
               cnt_d = cnt_q + TIMER_WIDTH'(1);
            end
            armed_d = (cnt_q >= thr) && (cd_q == '0);
         end
      end

      // Per-channel state registers
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q   <= '0;
            cd_q    <= '0;
            armed_q <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            cd_q    <= cd_d;
            armed_q <= armed_d;
         end
      end

      assign ch_armed_q[i] = armed_q;
   end

   // Round-robin pick: first armed channel at or after rr_ptr_q, wrapping
   always_comb begin
      rr_winner = '0;
      rr_found  = 1'b0;
      rr_idx    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         rr_idx = {1'b0, rr_ptr_q} + IW'(k);
         if (rr_idx >= IW'(NUM_CH)) begin
            rr_idx = rr_idx - IW'(NUM_CH);
         end
         if (!rr_found && ch_armed_q[rr_idx[CH_W-1:0]]) begin
            rr_found  = 1'b1;
            rr_winner = rr_idx[CH_W-1:0];
         end
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         bist_req_q   <= 1'b0;
         bist_abort_q <= 1'b0;
         bist_ch_q    <= '0;
         rr_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         bist_req_q   <= bist_req_d;
         bist_abort_q <= bist_abort_d;
         bist_ch_q    <= bist_ch_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   // FSM next state; done beats a simultaneous system reclaim in S_TEST
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (rr_found) state_d = S_REQ;
         end
         S_REQ: begin
            if (bist_ack && sel_valid) state_d = S_ABORT;
            else if (bist_ack)         state_d = S_TEST;
            else if (sel_valid)        state_d = S_IDLE;
         end
         S_TEST: begin
            if (bist_done)      state_d = S_IDLE;
            else if (sel_valid) state_d = S_ABORT;
         end
         S_ABORT: begin
            if (bist_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: request/abort/channel, pointer update, cooldown load
   always_comb begin
      bist_req_d   = bist_req_q;
      bist_abort_d = 1'b0;
      bist_ch_d    = bist_ch_q;
      rr_ptr_d     = rr_ptr_q;
      cd_load      = '0;
      case (state_q)
         S_IDLE: begin
            if (rr_found) begin
               bist_ch_d  = rr_winner;
               bist_req_d = 1'b1;
            end
         end
         S_REQ: begin
            if (bist_ack || sel_valid) begin
               bist_req_d   = 1'b0;
               // Engine already accepted, so it must be told to stop
               bist_abort_d = bist_ack && sel_valid;
            end
         end
         S_TEST: begin
            if (bist_done) begin
               rr_ptr_d           = next_ptr;
               cd_load[bist_ch_q] = 1'b1;
            end else if (sel_valid) begin
               bist_abort_d = 1'b1;
            end
         end
         S_ABORT: begin
            // Aborted test: advance fairness pointer but no cooldown
            if (bist_done) rr_ptr_d = next_ptr;
         end
         default: bist_req_d = 1'b0;
      endcase
   end

   assign ch_armed   = ch_armed_q;
   assign bist_req   = bist_req_q;
   assign bist_abort = bist_abort_q;
   assign bist_ch    = bist_ch_q;
   assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multi_idle_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_multi_idle_scheduler
//  Brief    : Directed scenarios plus randomized traffic for
//             multi_idle_scheduler, checked every cycle against a reference
//             model built on idle-run lengths and elapsed-time counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_idle_scheduler;
   localparam int N  = 4;
   localparam int TW = 16;
   localparam int CW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    sys_valid, ch_enable, ch_armed;
   logic [N*TW-1:0] threshold;
   logic [CW-1:0]   cooldown;
   logic            bist_req, bist_ack, bist_done, bist_abort, busy;
   logic [1:0]      bist_ch;

   int tests = 0;
   int fails = 0;

   // Reference model: idle run length, edges since last completed test,
   // cooldown captured at that completion, predicted outputs
   int           m_run   [N];
   int           m_since [N];
   int           m_cload [N];
   logic [N-1:0] m_armed;
   int           m_mode;      // 0 idle, 1 requesting, 2 testing, 3 aborting
   int           m_ch;
   bit           m_req, m_abort;
   int           m_next;

   always #5 clk = ~clk;

   multi_idle_scheduler #(.NUM_CH(N), .TIMER_WIDTH(TW), .CD_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .sys_valid  (sys_valid),
      .ch_enable  (ch_enable),
      .threshold  (threshold),
      .cooldown   (cooldown),
      .ch_armed   (ch_armed),
      .bist_req   (bist_req),
      .bist_ch    (bist_ch),
      .bist_ack   (bist_ack),
      .bist_done  (bist_done),
      .bist_abort (bist_abort),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int thr_of(input int i);
      return int'(threshold[i*TW +: TW]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_run[i]   = 0;
         m_since[i] = 1 << 24;
         m_cload[i] = 0;
      end
      m_armed = '0;
      m_mode  = 0;
      m_ch    = 0;
      m_req   = 0;
      m_abort = 0;
      m_next  = 0;
   endtask

   // Advance the model by one clock edge using the inputs now applied
   task automatic model_edge();
      logic [N-1:0] prev;
      int           dl;
      int           c;
      bit           sv;
      prev = m_armed;
      dl   = (m_mode == 2 && bist_done) ? m_ch : -1;
      for (int i = 0; i < N; i++) begin
         if (i == dl) begin
            m_run[i]   = 0;
            m_since[i] = 0;
            m_cload[i] = int'(cooldown);
            m_armed[i] = 1'b0;
         end else if (sys_valid[i] || !ch_enable[i]) begin
            m_run[i]   = 0;
            m_since[i] = m_since[i] + 1;
            m_armed[i] = 1'b0;
         end else begin
            m_run[i]   = m_run[i] + 1;
            m_since[i] = m_since[i] + 1;
            m_armed[i] = (m_run[i] >= thr_of(i) + 1) && (m_since[i] >= m_cload[i] + 1);
         end
      end
      m_abort = 0;
      sv = sys_valid[m_ch];
      case (m_mode)
         0: if (prev != '0) begin
               for (int k = N - 1; k >= 0; k--) begin
                  c = (m_next + k) % N;
                  if (prev[c]) m_ch = c;
               end
               m_req  = 1;
               m_mode = 1;
            end
         1: if (bist_ack && sv) begin
               m_req = 0; m_abort = 1; m_mode = 3;
            end else if (bist_ack) begin
               m_req = 0; m_mode = 2;
            end else if (sv) begin
               m_req = 0; m_mode = 0;
            end
         2: if (bist_done) begin
               m_mode = 0; m_next = (m_ch + 1) % N;
            end else if (sv) begin
               m_abort = 1; m_mode = 3;
            end
         default: if (bist_done) begin
               m_mode = 0; m_next = (m_ch + 1) % N;
            end
      endcase
   endtask

   task automatic compare_all();
      chk("ch_armed",   ch_armed,   m_armed);
      chk("bist_req",   bist_req,   m_req);
      chk("bist_ch",    bist_ch,    m_ch);
      chk("bist_abort", bist_abort, m_abort);
      chk("busy",       busy,       m_mode != 0);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   // Wait for a request, check the granted channel, then ack and complete it
   task automatic serve(input int exp_ch, input string tag);
      int n = 0;
      while (!bist_req && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_req_seen"}, bist_req, 1);
      chk(tag, bist_ch, exp_ch);
      bist_ack = 1; step(); bist_ack = 0;
      bist_done = 1; step(); bist_done = 0;
   endtask

   initial begin
      rst       = 1;
      sys_valid = '1;
      ch_enable = '1;
      for (int i = 0; i < N; i++) threshold[i*TW +: TW] = 16'd3;
      cooldown  = '0;
      bist_ack  = 0;
      bist_done = 0;
      model_reset();
      #2;
      chk("rst_armed", ch_armed, 0);
      chk("rst_req",   bist_req, 0);
      chk("rst_busy",  busy,     0);
      compare_all();
      @(negedge clk);
      rst = 0;
      step(); step();

      // Channel 0 goes idle with threshold 3: armed on edge 4, request on 5
      sys_valid = 4'b1110;
      repeat (3) step();
      chk("arm_edge3", ch_armed, 4'b0000);
      step();
      chk("arm_edge4", ch_armed, 4'b0001);
      chk("req_edge4", bist_req, 0);
      step();
      chk("req_edge5", bist_req, 1);
      chk("ch_edge5",  bist_ch,  0);
      bist_ack = 1; step(); bist_ack = 0;
      chk("test_busy", busy, 1);
      bist_done = 1; step(); bist_done = 0;
      sys_valid = '1;
      step();

      // Channels 1 and 3 idle together, cooldown 5 on completion
      cooldown  = 8'd5;
      sys_valid = 4'b0101;
      serve(1, "rr_first");
      serve(3, "rr_second");
      serve(1, "rr_third");
      sys_valid = '1;
      step();

      // Largest threshold: arms after 65536 idle edges and stays armed
      cooldown = '0;
      threshold[0 +: TW] = 16'hFFFF;
      sys_valid = 4'b1110;
      repeat (65535) step();
      chk("sat_before", ch_armed[0], 0);
      step();
      chk("sat_arm", ch_armed[0], 1);
      repeat (5) step();
      chk("sat_nowrap", ch_armed[0], 1);

      // Enter test, then reset asynchronously mid-test
      bist_ack = 1; step(); bist_ack = 0;
      chk("pre_rst_busy", busy, 1);
      #2 rst = 1;
      #1;
      chk("mid_rst_req",   bist_req,   0);
      chk("mid_rst_abort", bist_abort, 0);
      chk("mid_rst_busy",  busy,       0);
      chk("mid_rst_armed", ch_armed,   0);
      chk("mid_rst_ch",    bist_ch,    0);
      model_reset();
      @(negedge clk);
      rst = 0;

      // Randomized traffic with a reactive engine model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 500 == 0) begin
            for (int i = 0; i < N; i++) threshold[i*TW +: TW] = 16'($urandom_range(0, 4));
            sys_valid = '1;
         end else begin
            for (int i = 0; i < N; i++) begin
               if ($urandom_range(0, 9) == 0)  sys_valid[i] = ~sys_valid[i];
               if ($urandom_range(0, 39) == 0) ch_enable[i] = ~ch_enable[i];
            end
            if ((m_mode == 1 || m_mode == 2) && $urandom_range(0, 7) == 0) sys_valid[m_ch] = 1'b1;
         end
         if (cyc % 200 == 0) cooldown = 8'($urandom_range(0, 6));
         bist_ack  = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         bist_done = (m_mode >= 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         step();
      end
      bist_ack  = 0;
      bist_done = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
